// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package otter_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    D_PRIO  = 1'b0,
    I_FORCE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic is_data;
    logic is_write;
  } mem_tag_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the MCU requesters, the arbiter and the BRAM.
// slave: arbiter view. master: MCU/BRAM (environment) view.
interface otter_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_imem_req;
  logic [ADDR_WIDTH-1:0] i_imem_addr;
  logic                  o_imem_gnt;
  logic                  o_imem_rvalid;
  logic [31:0]           o_imem_rdata;

  logic                  i_dmem_req;
  logic                  i_dmem_we;
  logic [3:0]            i_dmem_sel;
  logic [ADDR_WIDTH-1:0] i_dmem_addr;
  logic [31:0]           i_dmem_wdata;
  logic                  o_dmem_gnt;
  logic                  o_dmem_rvalid;
  logic [31:0]           o_dmem_rdata;

  logic                  o_mem_en;
  logic [3:0]            o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [31:0]           i_mem_rdata;

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    input  i_dmem_req, i_dmem_we, i_dmem_sel, i_dmem_addr, i_dmem_wdata,
    output o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    output i_dmem_req, i_dmem_we, i_dmem_sel, i_dmem_addr, i_dmem_wdata,
    input  o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );

endinterface

// File: rtl/otter_mem_tag_pipe.sv
// Tag shift register that follows each BRAM access through the read
// latency so the response can be steered back to its requester.
module otter_mem_tag_pipe
  import otter_mem_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  mem_tag_t i_load,
  output mem_tag_t o_tail
);

  mem_tag_t stage_q [MEM_LAT];

  // Load stage 0 every cycle (invalid when idle) and shift the rest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEM_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= i_load;
      for (int i = 1; i < MEM_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_tail = stage_q[MEM_LAT-1];

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing the single-port unified BRAM between instruction fetch
// and data accesses. Data wins conflicts until the instruction port has
// lost MAX_WAIT cycles in a row, then the instruction port is forced once.
//
// state   | meaning
// D_PRIO  | data port wins a conflict
// I_FORCE | instruction port wins a conflict (starvation relief)
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_WAIT   = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  otter_mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  arb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             imem_gnt, dmem_gnt;
  mem_tag_t         tag_load, tag_tail;

  // Grants are gated by reset so nothing reaches the BRAM while held in reset.
  always_comb begin
    imem_gnt = !i_rst && bus.i_imem_req && (!bus.i_dmem_req || state_q == I_FORCE);
    dmem_gnt = !i_rst && bus.i_dmem_req && !(bus.i_imem_req && state_q == I_FORCE);
  end

  // Consecutive-loss counter for the instruction port; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.i_imem_req || imem_gnt) cnt_d = '0;
    else if (cnt_q != '1)            cnt_d = cnt_q + 1'b1;
  end

  // Arbitration FSM; the switch uses the next count so the instruction port
  // wins on the cycle right after its MAX_WAIT-th loss.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= D_PRIO;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        D_PRIO:  if (cnt_d >= MAX_WAIT_C) state_q <= I_FORCE;
        I_FORCE: if (imem_gnt)            state_q <= D_PRIO;
      endcase
    end
  end

  // Issue path to the BRAM, combinational from the winner.
  always_comb begin
    bus.o_imem_gnt  = imem_gnt;
    bus.o_dmem_gnt  = dmem_gnt;
    bus.o_mem_en    = imem_gnt | dmem_gnt;
    bus.o_mem_we    = (dmem_gnt && bus.i_dmem_we) ? bus.i_dmem_sel : 4'b0000;
    bus.o_mem_addr  = dmem_gnt ? bus.i_dmem_addr :
                      (imem_gnt ? bus.i_imem_addr : '0);
    bus.o_mem_wdata = dmem_gnt ? bus.i_dmem_wdata : 32'h0;
  end

  // Tag describing this cycle's issue (all-zero when nothing is issued).
  always_comb begin
    tag_load.valid    = imem_gnt | dmem_gnt;
    tag_load.is_data  = dmem_gnt;
    tag_load.is_write = dmem_gnt & bus.i_dmem_we;
  end

  otter_mem_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (tag_load),
    .o_tail (tag_tail)
  );

  // Response steering from the retiring tag; write completions carry no data.
  always_comb begin
    bus.o_imem_rvalid = tag_tail.valid & !tag_tail.is_data;
    bus.o_dmem_rvalid = tag_tail.valid &  tag_tail.is_data;
    bus.o_imem_rdata  = bus.o_imem_rvalid ? bus.i_mem_rdata : 32'h0;
    bus.o_dmem_rdata  = (bus.o_dmem_rvalid && !tag_tail.is_write) ? bus.i_mem_rdata : 32'h0;
  end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
Shares the single-port unified BRAM between the MCU instruction-fetch port and the data port.
- Accepts at most one request per cycle and issues it to the BRAM.
- Tracks in-flight transactions through the fixed-latency read pipeline and routes each response back to the requester that issued it.
- Sits inside otter_soc between the MCU and the memory block. Replaces the current separate IMEM/DMEM latency model.

Parameters:
ADDR_WIDTH, 32, byte-address width on both requester ports and the BRAM port.
MEM_LAT, 2, BRAM read latency in cycles from issue to i_mem_rdata valid; legal range 1..8.
MAX_WAIT, 4, consecutive cycles an instruction request may lose arbitration before it is forced; legal range 1..15.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous assert, active-high
i_imem_req  in  1  instruction read request
i_imem_addr  in  ADDR_WIDTH  instruction byte address, word-aligned
o_imem_gnt  out  1  instruction request accepted this cycle
o_imem_rvalid  out  1  instruction read data valid
o_imem_rdata  out  32  instruction read data
i_dmem_req  in  1  data request
i_dmem_we  in  1  1 = write, 0 = read
i_dmem_sel  in  4  byte enables
i_dmem_addr  in  ADDR_WIDTH  data byte address
i_dmem_wdata  in  32  write data
o_dmem_gnt  out  1  data request accepted this cycle
o_dmem_rvalid  out  1  data response; read data valid, or write completion
o_dmem_rdata  out  32  data read data; 0 on write completions
o_mem_en  out  1  BRAM access strobe
o_mem_we  out  4  BRAM byte write enables
o_mem_addr  out  ADDR_WIDTH  BRAM byte address
o_mem_wdata  out  32  BRAM write data
i_mem_rdata  in  32  BRAM read data, MEM_LAT cycles after o_mem_en

Behaviour:
Handshake
- A requester holds req and all request fields stable until it samples gnt=1 on a rising edge.
- gnt is combinational from req and arbiter state. At most one gnt is high per cycle.
- Issue: on a granted cycle, o_mem_en=1 and o_mem_addr/o_mem_wdata carry the winner's fields; these outputs are combinational, same cycle.
- o_mem_we = i_dmem_sel when the data port wins with we=1, otherwise 0. Instruction issues always have o_mem_we=0.
- A data request with we=1 and sel=0 is still granted and acknowledged.

Arbitration
- Two-state FSM:
  - D_PRIO (reset state): data port wins a conflict.
  - I_FORCE: instruction port wins a conflict.
- Starvation counter, 4 bits, reset 0:
  - Increments each cycle i_imem_req=1 and o_imem_gnt=0.
  - Clears on o_imem_gnt=1 or when i_imem_req=0.
- D_PRIO -> I_FORCE when the counter reaches MAX_WAIT.
- I_FORCE -> D_PRIO on the cycle o_imem_gnt=1.
- A lone requester is always granted in either state.

Response routing
- Tag shift register, MEM_LAT stages, 2 bits each: {valid, is_data}, plus a parallel 1-bit is_write per stage.
- Stage 0 is loaded on issue and clears when nothing is issued. The register shifts every cycle.
- The final stage drives the responses:
  - o_imem_rvalid = valid & !is_data, with o_imem_rdata = i_mem_rdata.
  - o_dmem_rvalid = valid & is_data, with o_dmem_rdata = is_write ? 0 : i_mem_rdata.
- rdata outputs are 0 when the matching rvalid=0.
- Throughput: one issue per cycle, pipelined. Responses return in issue order with exactly MEM_LAT cycles of latency.
- Requesters have no backpressure on responses and must accept rvalid unconditionally.

Reset
- Asynchronous assert:
  - All tag stages invalid.
  - FSM returns to D_PRIO.
  - Counter set to 0.
- Reset values: every gnt, rvalid, rdata and mem output is 0. o_mem_en is also forced 0 while i_rst=1.
- Reset mid-flight drops all pending responses. No rvalid is produced for pre-reset issues.
- Synchronous release: requests are considered from the first edge after deassertion.

Boundaries
- Both ports requesting every cycle: the instruction port is granted exactly once per MAX_WAIT+1 cycles.
- Simultaneous issue and retire: a new issue in the same cycle as a retirement is legal.
- Addresses are passed unmodified. Range decode and alignment are the caller's responsibility.

Decomposition:
- Package otter_mem_pkg holds:
  - typedef arb_state_t {D_PRIO, I_FORCE};
  - packed struct mem_tag_t {valid, is_data, is_write};
  - localparam CNT_W=4.
- One sub-module, otter_mem_tag_pipe: MEM_LAT-deep mem_tag_t shift register with async reset. Exposes stage-0 load and final-stage output.

Test Plan:
1. Instruction only, MEM_LAT=2, read 0x8000_1000 with BRAM word 0x0000_0013 -> gnt same cycle; o_imem_rvalid=1 and o_imem_rdata=0x0000_0013 exactly 2 cycles later.
2. Data write: addr 0x8000_2000, sel=4'b0011, wdata 0xDEADBEEF -> o_mem_we=4'b0011 on the issue cycle; o_dmem_rvalid=1 with o_dmem_rdata=0 two cycles later; a readback returns 0x0000BEEF where the upper bytes were prior zeros.
3. Both ports requesting continuously, MAX_WAIT=4 -> data granted 4 consecutive cycles, instruction granted on the 5th; pattern repeats; no cycle has both gnt high.
4. Back-to-back interleaved I,D,I reads of distinct words -> three consecutive rvalids, routed to the correct ports in order with the correct data.
5. Assert i_rst one cycle after a data read issue -> all outputs 0 immediately; no o_dmem_rvalid after release; FSM in D_PRIO.
6. Data port idle while the instruction request holds for 3 cycles -> granted on the first cycle; counter stays 0.
